// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline stage register with flush, bubble     |
// |                  insertion and a saturating bubble counter.                 |
// |                  Define PIPE_STAGE_SKID_EN for a 2-entry skid variant.      |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              bubble,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              consume;

    assign accept  = in_valid && in_ready;
    assign consume = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Registered skid occupancy only: no path from out_ready to in_ready.
    assign in_ready = cpu_rst_n && !skid_valid && !flush && !bubble;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (consume) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
                skid_data  <= '0;
                skid_ctrl  <= '0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end
        end
    end
`else
    assign in_ready = cpu_rst_n && (!main_valid || out_ready) && !flush && !bubble;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
        end else if (consume) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end
    end
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Scoreboard bench for pipe_stage_reg: the stage is modelled as a bounded FIFO of payloads.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic [15:0] in_ctrl;
    logic        flush;
    logic        bubble;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [15:0] out_ctrl;
    logic [3:0]  bubble_cnt;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .CNT_W(4)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .bubble     (bubble),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    int           checks = 0;
    int           errors = 0;
    logic [111:0] sb_q[$];
    int           exp_cnt = 0;

    task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares presented payload against the FIFO head, pops on consumption.
    always @(negedge cpu_clk) begin
        chk("out_valid", 112'(out_valid), 112'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("out_data", 112'(out_data), 112'(sb_q[0][95:0]));
            chk("out_ctrl", 112'(out_ctrl), 112'(sb_q[0][111:96]));
        end else begin
            chk("out_ctrl_idle", 112'(out_ctrl), 112'(0));
        end
        chk("bubble_cnt", 112'(bubble_cnt), 112'(exp_cnt));
        if (sb_q.size() != 0 && out_ready)
            void'(sb_q.pop_front());
    end

    // One clock of stimulus; the model advances after the monitor has sampled.
    task automatic cycle(input logic v, input logic [95:0] d, input logic [15:0] c,
                         input logic fl, input logic bub, input logic ordy);
        logic exp_rdy;
        logic acc;
        @(posedge cpu_clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        bubble    = bub;
        out_ready = ordy;
        #1;
        if (CAP == 2)
            exp_rdy = cpu_rst_n && !fl && !bub && (sb_q.size() < 2);
        else
            exp_rdy = cpu_rst_n && !fl && !bub && (sb_q.size() == 0 || ordy);
        chk("in_ready", 112'(in_ready), 112'(exp_rdy));
        acc = v && exp_rdy;
        @(negedge cpu_clk);
        #1;
        if (!cpu_rst_n) begin
            sb_q.delete();
        end else begin
            if (fl)
                sb_q.delete();
            else if (acc)
                sb_q.push_back({c, d});
            if (bub && exp_cnt != 15)
                exp_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic apply_reset();
        cpu_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 112'(out_valid), 112'(0));
        chk("rst_out_data", 112'(out_data), 112'(0));
        chk("rst_out_ctrl", 112'(out_ctrl), 112'(0));
        chk("rst_bubble_cnt", 112'(bubble_cnt), 112'(0));
        chk("rst_in_ready", 112'(in_ready), 112'(0));
        sb_q.delete();
        exp_cnt = 0;
        idle(2);
        cpu_rst_n = 1'b1;
    endtask

    task automatic rand_run(input int n);
        logic v, fl, bub, ordy;
        for (int i = 0; i < n; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            bub  = ($urandom_range(0, 7) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(v, {$urandom, $urandom, $urandom}, 16'($urandom), fl, bub, ordy);
        end
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        bubble    = 1'b0;
        out_ready = 1'b0;
        #2;
        apply_reset();

        // Streaming at full throughput
        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 96'(i), 16'(i), 1'b0, 1'b0, 1'b1);
        idle(2);

        // Back-pressure: A held while B is offered
        cycle(1'b1, 96'h11, 16'h3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 96'h22, 16'h5, 1'b0, 1'b0, 1'b0);
        if (CAP == 1)
            cycle(1'b1, 96'h22, 16'h5, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Single bubble mid-stream
        cycle(1'b1, 96'h31, 16'h1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 96'h32, 16'h2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 96'h33, 16'h4, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 96'h34, 16'h8, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 96'h35, 16'h9, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("bubble_cnt_one", 112'(bubble_cnt), 112'(1));

        // Flush with the stage full and input offered
        cycle(1'b1, 96'hA1, 16'h7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 96'hA2, 16'h7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 96'hA3, 16'h7, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("flush_out_valid", 112'(out_valid), 112'(0));
        chk("flush_out_data", 112'(out_data), 112'(0));
        chk("flush_out_ctrl", 112'(out_ctrl), 112'(0));
        idle(2);

        // Counter saturation (CNT_W=4)
        for (int i = 0; i < 19; i++)
            cycle(1'b1, 96'hB0, 16'h1, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("bubble_cnt_sat", 112'(bubble_cnt), 112'(15));

        // Reset while the stage is full
        cycle(1'b1, 96'hC1, 16'h6, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 96'hC2, 16'h6, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        cycle(1'b1, 96'h55, 16'hA, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_valid", 112'(out_valid), 112'(1));
        chk("post_rst_data", 112'(out_data), 112'(96'h55));
        idle(2);

        rand_run(300);
        idle(3);
        apply_reset();
        rand_run(300);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
